// File: rtl/conv_encoder_output_reader.sv
// Streams one frame of padded conv-encoder feature maps out of memory, plane by plane, through a 2-entry FIFO.
// Optional build macro: CONV_ENCODER_READER_RELU_EN clamps negative memory words to zero before buffering.
module conv_encoder_output_reader #(
    parameter int DATA_W      = 18,
    parameter int ADDR_W      = 14,
    parameter int ROW_PITCH   = 70,
    parameter int ROW_FIRST   = 3,
    parameter int ROW_LAST    = 182,
    parameter int COL_FIRST   = 3,
    parameter int COL_LAST    = 66,
    parameter int NUM_FILTERS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        rd_filter,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_pixel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_filter,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] START_ADDR  = ADDR_W'(ROW_FIRST * ROW_PITCH + COL_FIRST);
    localparam logic [ADDR_W-1:0] ROW_STEP    = ADDR_W'(ROW_PITCH - (COL_LAST - COL_FIRST));
    localparam logic [ADDR_W-1:0] ROW_FIRST_L = ADDR_W'(ROW_FIRST);
    localparam logic [ADDR_W-1:0] ROW_LAST_L  = ADDR_W'(ROW_LAST);
    localparam logic [ADDR_W-1:0] COL_FIRST_L = ADDR_W'(COL_FIRST);
    localparam logic [ADDR_W-1:0] COL_LAST_L  = ADDR_W'(COL_LAST);
    localparam logic [3:0]        LAST_FILTER = 4'(NUM_FILTERS - 1);
    localparam int                ENTRY_W     = DATA_W + 5;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]   col_q, col_d;
    logic [3:0]          filter_q, filter_d;
    logic                infl_q, infl_d;
    logic [3:0]          infl_filter_q, infl_filter_d;
    logic                infl_last_q, infl_last_d;
    logic [ENTRY_W-1:0]  fifo_q [2];
    logic [ENTRY_W-1:0]  fifo_d [2];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          count_q, count_d;

    logic                pop;
    logic                push;
    logic [1:0]          occ;
    logic                issue;
    logic                col_last;
    logic                plane_end;
    logic                frame_end;
    logic [DATA_W-1:0]   pixel_in;
    logic [ENTRY_W-1:0]  head;

    assign pop  = (count_q != 2'd0) && out_ready;
    assign push = infl_q;

    // Occupancy counts the slot freed by this cycle's pop, which keeps one read per cycle under full rate
    // while never letting buffered plus in-flight words exceed the two FIFO slots.
    assign occ   = count_q - 2'(pop) + 2'(infl_q);
    assign issue = (state_q == READ) && (occ < 2'd2);

    assign col_last  = (col_q == COL_LAST_L);
    assign plane_end = col_last && (row_q == ROW_LAST_L);
    assign frame_end = plane_end && (filter_q == LAST_FILTER);

`ifdef CONV_ENCODER_READER_RELU_EN
    assign pixel_in = rd_data[DATA_W-1] ? '0 : rd_data;
`else
    assign pixel_in = rd_data;
`endif

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        row_d         = row_q;
        col_d         = col_q;
        filter_d      = filter_q;
        infl_d        = issue;
        infl_filter_d = filter_q;
        infl_last_d   = plane_end;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = READ;
                    addr_d   = START_ADDR;
                    row_d    = ROW_FIRST_L;
                    col_d    = COL_FIRST_L;
                    filter_d = 4'd0;
                end
            end
            READ: begin
                if (issue) begin
                    if (plane_end) begin
                        addr_d   = START_ADDR;
                        row_d    = ROW_FIRST_L;
                        col_d    = COL_FIRST_L;
                        filter_d = frame_end ? 4'd0 : filter_q + 4'd1;
                        if (frame_end) begin
                            state_d = DRAIN;
                        end
                    end else if (col_last) begin
                        addr_d = addr_q + ROW_STEP;
                        row_d  = row_q + ADDR_W'(1);
                        col_d  = COL_FIRST_L;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        col_d  = col_q + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if ((count_q == 2'd0) && !infl_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Filter index and plane-end flag ride alongside the pixel so they stay aligned through stalls.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + 2'(push) - 2'(pop);
        if (push) begin
            fifo_d[wr_ptr_q] = {infl_last_q, infl_filter_q, pixel_in};
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            addr_q        <= START_ADDR;
            row_q         <= ROW_FIRST_L;
            col_q         <= COL_FIRST_L;
            filter_q      <= 4'd0;
            infl_q        <= 1'b0;
            infl_filter_q <= 4'd0;
            infl_last_q   <= 1'b0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            row_q         <= row_d;
            col_q         <= col_d;
            filter_q      <= filter_d;
            infl_q        <= infl_d;
            infl_filter_q <= infl_filter_d;
            infl_last_q   <= infl_last_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo_slot
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                fifo_q[gi] <= '0;
            end else begin
                fifo_q[gi] <= fifo_d[gi];
            end
        end
    end

    assign head       = fifo_q[rd_ptr_q];
    assign out_valid  = (count_q != 2'd0);
    assign out_pixel  = out_valid ? head[DATA_W-1:0] : '0;
    assign out_filter = out_valid ? head[DATA_W+3:DATA_W] : 4'd0;
    assign out_last   = out_valid ? head[ENTRY_W-1] : 1'b0;

    assign rd_en     = issue;
    assign rd_addr   = addr_q;
    assign rd_filter = filter_q;
    assign busy      = (state_q == READ) || (state_q == DRAIN);
    assign done      = (state_q == DONE);

endmodule

// File: doc/conv_encoder_output_reader.md
CONV_ENCODER_OUTPUT_READER -- requirements
Module: conv_encoder_output_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 18, pixel width (signed).
REQ-002 SHALL have parameter ADDR_W, default 14, feature-map address width.
REQ-003 SHALL have parameter ROW_PITCH, default 70, padded row length in words.
REQ-004 SHALL have parameters ROW_FIRST=3, ROW_LAST=182, COL_FIRST=3, COL_LAST=66, which bound the valid (unpadded) 180x64 region.
REQ-005 SHALL have parameter NUM_FILTERS, default 16, filter planes per frame.
REQ-006 SHALL have one clock; reset is asynchronous and active-low: ports clk and rst, both inputs of 1 bit each, with rst=0 resetting the block.
REQ-007 start  in  1  one-cycle request to read one full frame.
REQ-008 rd_en  out  1  memory read strobe.
REQ-009 rd_addr  out  ADDR_W  padded-layout word address.
REQ-010 rd_filter  out  4  filter-plane select.
REQ-011 rd_data  in  DATA_W  signed memory data, valid exactly 1 cycle after rd_en.
REQ-012 out_pixel  out  DATA_W  signed streamed pixel.
REQ-013 out_valid  out  1  out_pixel/out_filter/out_last valid.
REQ-014 out_ready  in  1  downstream accept.
REQ-015 out_filter  out  4  filter index of out_pixel.
REQ-016 out_last  out  1  marks the final pixel (row ROW_LAST, col COL_LAST) of a filter plane.
REQ-017 busy  out  1  high from the cycle after an accepted start until done.
REQ-018 done  out  1  one-cycle pulse after the last pixel of filter NUM_FILTERS-1 is accepted.

Function
REQ-019 The FSM SHALL have states IDLE, READ, DRAIN, DONE; IDLE->READ on start; READ->DRAIN after the last address of the last filter is issued; DRAIN->DONE when the output FIFO and in-flight read are empty; DONE->IDLE unconditionally after 1 cycle.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 Addresses SHALL start at ROW_FIRST*ROW_PITCH+COL_FIRST (213) for every filter.
REQ-022 After an issued read at column COL_LAST, the next address SHALL be +ROW_PITCH-(COL_LAST-COL_FIRST) (+7); otherwise it SHALL be +1.
REQ-023 After the read at (ROW_LAST, COL_LAST) (address 12806), rd_filter SHALL increment and the address SHALL restart at 213; 11520 reads SHALL be issued per filter.
REQ-024 Output SHALL pass through a 2-entry FIFO; rd_en SHALL assert only when (FIFO count + in-flight reads) < 2, so that no data is ever dropped.
REQ-025 Under continuous out_ready, after the first read one pixel SHALL be output per cycle; the first out_valid SHALL occur 2 cycles after the first rd_en.
REQ-026 out_pixel/out_filter/out_last SHALL hold while out_valid=1 and out_ready=0.
REQ-027 A simultaneous FIFO push and pop SHALL leave the count unchanged.
REQ-028 out_filter and out_last SHALL travel with the data through the FIFO.
REQ-029 rd_en SHALL remain 0 in IDLE, DRAIN and DONE.

Reset
REQ-030 On rst=0 the block SHALL asynchronously enter IDLE with rd_en=0, rd_addr=213, rd_filter=0, out_valid=0, out_pixel=0, out_filter=0, out_last=0, busy=0, done=0, and the FIFO empty.
REQ-031 Reset mid-frame SHALL discard in-flight data; a new start after rst rises SHALL restart at filter 0, address 213.

Configuration
REQ-032 With CONV_ENCODER_READER_RELU_EN defined, a negative rd_data SHALL be replaced by 0 before entering the FIFO; without the macro, data SHALL pass unchanged.

Verification
REQ-033 Reset then start with out_ready=1 -> rd_addr sequence 213,214..276,283; first out_valid 2 cycles after the first rd_en; 184320 pixels total; done pulses once.
REQ-034 Memory value = address -> at filter 0 the 64th pixel is 276, the 65th is 283, and the pixel with out_last=1 is 12806; rd_filter goes to 1 on the next address, 213.
REQ-035 Drive out_ready with a random 50% pattern -> no lost or duplicated pixels; outputs stay stable while stalled; FIFO count never exceeds 2.
REQ-036 Pulse start during READ -> ignored; total pixel count still 184320.
REQ-037 Assert rst=0 at pixel 5000 -> all outputs take reset values immediately; a restart from filter 0 completes normally.
REQ-038 rd_data=-5 -> out_pixel=0 with CONV_ENCODER_READER_RELU_EN defined, and -5 without it.
